// File: rtl/load_store_unit.sv
// Load/store engine: decoded memory command -> word-addressed, byte-enabled req/ack bus.
// Latency: bus access done 2+ cycles after start (ack in cycle k -> done in k+1); NONE/misaligned done in cycle 1.
// Backpressure: start is ignored unless IDLE; bus_req is held until bus_ack or TIMEOUT_CYCLES expire.
//
// Ports: clk/rst (async active-high); start, mem_op, mem_read_type, mem_write_mask, addr, wdata
// command inputs; busy/done/rdata/misaligned/timeout status; bus_req/bus_we/bus_addr/bus_be/
// bus_wdata request side (all registered), bus_ack/bus_rdata response side.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  mem_op,
   input  logic [2:0]  mem_read_type,
   input  logic [3:0]  mem_write_mask,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        timeout,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam logic [1:0] MEM_OP_NONE  = 2'd0;
   localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
   localparam logic [1:0] MEM_OP_STORE = 2'd2;

   localparam logic [2:0] MEM_RD_BYTE = 3'd0;
   localparam logic [2:0] MEM_RD_HALF = 3'd1;
   localparam logic [2:0] MEM_RD_WORD = 3'd2;
   localparam logic [2:0] MEM_RD_B_U  = 3'd4;
   localparam logic [2:0] MEM_RD_H_U  = 3'd5;
   localparam logic [2:0] MEM_RD_NONE = 3'd7;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  rt_q;
   logic [1:0]  off_q;
   logic        is_load_q;
   logic [15:0] cnt_q;

   // ---------------- command decode (combinational on the inputs) ----------------
   logic        is_load, is_store, eff_none, mis;
   logic [3:0]  rd_mask, acc_be, be_shift;
   logic [31:0] lane_wdata;

   always_comb begin
      is_load  = (mem_op == MEM_OP_LOAD);
      is_store = (mem_op == MEM_OP_STORE);

      rd_mask = 4'b0000;
      case (mem_read_type)
         MEM_RD_BYTE, MEM_RD_B_U: rd_mask = 4'b0001;
         MEM_RD_HALF, MEM_RD_H_U: rd_mask = 4'b0011;
         MEM_RD_WORD:             rd_mask = 4'b1111;
         default:                 rd_mask = 4'b0000;
      endcase

      // Loads size from the read type, stores from the write mask; an empty
      // size (read type NONE / mask 0000 / unknown encoding) behaves as NONE.
      acc_be   = is_load ? rd_mask : (is_store ? mem_write_mask : 4'b0000);
      eff_none = (acc_be == 4'b0000);

      mis = ((acc_be == 4'b0011) && addr[0]) ||
            ((acc_be == 4'b1111) && (addr[1:0] != 2'b00));

      be_shift = acc_be << addr[1:0];

      if (mem_write_mask == 4'b1111)
         lane_wdata = wdata;
      else if (mem_write_mask == 4'b0011)
         lane_wdata = {2{wdata[15:0]}};
      else
         lane_wdata = {4{wdata[7:0]}};
   end

   // ---------------- load extraction ----------------
   logic [31:0] shifted, ext;

   always_comb begin
      shifted = bus_rdata >> {off_q, 3'b000};
      case (rt_q)
         MEM_RD_BYTE: ext = {{24{shifted[7]}}, shifted[7:0]};
         MEM_RD_B_U:  ext = {24'b0, shifted[7:0]};
         MEM_RD_HALF: ext = {{16{shifted[15]}}, shifted[15:0]};
         MEM_RD_H_U:  ext = {16'b0, shifted[15:0]};
         default:     ext = shifted;
      endcase
   end

   // ---------------- FSM ----------------
   logic accept, go_bus, fin_ack, fin_to;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      go_bus  = 1'b0;
      fin_ack = 1'b0;
      fin_to  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (eff_none || mis) begin
                  state_d = S_DONE;
               end else begin
                  go_bus  = 1'b1;
                  state_d = S_BUS;
               end
            end
         end
         S_BUS: begin
            // An ack arriving in the expiry cycle still completes normally.
            if (bus_ack) begin
               fin_ack = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               fin_to  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- registered datapath / outputs ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         rdata      <= 32'b0;
         misaligned <= 1'b0;
         timeout    <= 1'b0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'b0;
         bus_be     <= 4'b0;
         bus_wdata  <= 32'b0;
         rt_q       <= MEM_RD_NONE;
         off_q      <= 2'b0;
         is_load_q  <= 1'b0;
         cnt_q      <= 16'b0;
      end else begin
         busy <= (state_d != S_IDLE);
         done <= (state_d == S_DONE);

         if (accept) begin
            rt_q       <= mem_read_type;
            off_q      <= addr[1:0];
            is_load_q  <= is_load;
            misaligned <= mis && !eff_none;
            timeout    <= 1'b0;
            rdata      <= 32'b0;
            cnt_q      <= 16'b0;
            if (go_bus) begin
               bus_req   <= 1'b1;
               bus_we    <= is_store;
               bus_addr  <= {addr[31:2], 2'b00};
               bus_be    <= be_shift;
               bus_wdata <= lane_wdata;
            end
         end

         if (state_q == S_BUS) begin
            if (fin_ack) begin
               bus_req <= 1'b0;
               if (is_load_q) rdata <= ext;
            end else if (fin_to) begin
               bus_req <= 1'b0;
               timeout <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   localparam logic [1:0] OP_NONE = 2'd0, OP_LD = 2'd1, OP_ST = 2'd2;
   localparam logic [2:0] RB = 3'd0, RH = 3'd1, RW = 3'd2, RBU = 3'd4, RHU = 3'd5, RN = 3'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mem_op;
   logic [2:0]  mem_read_type;
   logic [3:0]  mem_write_mask;
   logic [31:0] addr, wdata;
   logic        busy, done, misaligned, timeout;
   logic [31:0] rdata;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .mem_op(mem_op),
      .mem_read_type(mem_read_type), .mem_write_mask(mem_write_mask),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
      .misaligned(misaligned), .timeout(timeout), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [2:0]  rt;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_wait;   // BUS cycles without ack before ack; -1 = never
      logic [31:0] brd;
      int          exp_done;   // cycle of done, start in cycle 0
      int          exp_nreq;   // cycles with bus_req high
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_mis;
      logic        exp_to;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      start = 1'b0; mem_op = OP_NONE; mem_read_type = RN; mem_write_mask = 4'b0;
      addr = 32'b0; wdata = 32'b0; bus_ack = 1'b0; bus_rdata = 32'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int nreq = 0;
      int done_cyc = -1;
      logic        f_we = 1'b0;
      logic [31:0] f_addr = 32'b0, f_wdata = 32'b0;
      logic [3:0]  f_be = 4'b0;
      logic [31:0] r_rd = 32'b0;
      logic        r_mis = 1'b0, r_to = 1'b0;
      @(negedge clk);
      start = 1'b1; mem_op = v.op; mem_read_type = v.rt; mem_write_mask = v.mask;
      addr = v.addr; wdata = v.wdata;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         start = 1'b0; bus_ack = 1'b0;
         if (done) begin
            done_cyc = cyc; r_rd = rdata; r_mis = misaligned; r_to = timeout;
            break;
         end
         if (bus_req) begin
            nreq++;
            if (nreq == 1) begin
               f_we = bus_we; f_addr = bus_addr; f_be = bus_be; f_wdata = bus_wdata;
            end
            if (v.ack_wait >= 0 && nreq == v.ack_wait + 1) begin
               bus_ack = 1'b1; bus_rdata = v.brd;
            end
         end
      end
      chk({v.name, ".done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
      chk({v.name, ".req_cycles"}, 32'(nreq), 32'(v.exp_nreq));
      chk({v.name, ".misaligned"}, 32'(r_mis), 32'(v.exp_mis));
      chk({v.name, ".timeout"}, 32'(r_to), 32'(v.exp_to));
      if (v.chk_rd) chk({v.name, ".rdata"}, r_rd, v.exp_rd);
      if (v.exp_nreq > 0) begin
         chk({v.name, ".bus_we"}, 32'(f_we), 32'(v.exp_we));
         chk({v.name, ".bus_addr"}, f_addr, v.exp_addr);
         chk({v.name, ".bus_be"}, 32'(f_be), 32'(v.exp_be));
         if (v.exp_we) chk({v.name, ".bus_wdata"}, f_wdata, v.exp_wdata);
      end
      @(negedge clk);
      chk({v.name, ".done_pulse_end"}, 32'(done), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.bus_req", 32'(bus_req), 32'd0);
      chk("rst.bus_we", 32'(bus_we), 32'd0);
      chk("rst.bus_addr", bus_addr, 32'd0);
      chk("rst.bus_be", 32'(bus_be), 32'd0);
      chk("rst.bus_wdata", bus_wdata, 32'd0);
      chk("rst.rdata", rdata, 32'd0);
      chk("rst.flags", {30'b0, misaligned, timeout}, 32'd0);
      rst = 1'b0;

      //            name     op      rt   mask     addr          wdata         ack brd           done nreq we  exp_addr      be       exp_wdata     chk  exp_rd       mis   to
      vq.push_back('{"lb",    OP_LD, RB,  4'b0000, 32'h0000_1003, 32'h0,        0, 32'h80FF_1234, 2, 1, 1'b0, 32'h0000_1000, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80, 1'b0, 1'b0});
      vq.push_back('{"lbu",   OP_LD, RBU, 4'b0000, 32'h0000_1003, 32'h0,        0, 32'h80FF_1234, 2, 1, 1'b0, 32'h0000_1000, 4'b1000, 32'h0,        1'b1, 32'h0000_0080, 1'b0, 1'b0});
      vq.push_back('{"sh",    OP_ST, RH,  4'b0011, 32'h0000_2002, 32'hDEAD_BEEF, 3, 32'h1234_5678, 5, 4, 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0,        1'b0, 1'b0});
      vq.push_back('{"lw_mis",OP_LD, RW,  4'b0000, 32'h0000_3001, 32'h0,        0, 32'h0,         1, 0, 1'b0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0});
      vq.push_back('{"lh",    OP_LD, RH,  4'b0000, 32'h0000_3002, 32'h0,        0, 32'h8001_0000, 2, 1, 1'b0, 32'h0000_3000, 4'b1100, 32'h0,        1'b1, 32'hFFFF_8001, 1'b0, 1'b0});
      vq.push_back('{"sw_to", OP_ST, RW,  4'b1111, 32'h0000_4000, 32'h1122_3344, -1, 32'h0,        5, 4, 1'b1, 32'h0000_4000, 4'b1111, 32'h1122_3344, 1'b1, 32'h0,        1'b0, 1'b1});
      vq.push_back('{"sw_ack4",OP_ST,RW,  4'b1111, 32'h0000_4000, 32'h1122_3344, 3, 32'h0,         5, 4, 1'b1, 32'h0000_4000, 4'b1111, 32'h1122_3344, 1'b0, 32'h0,        1'b0, 1'b0});
      vq.push_back('{"none",  OP_NONE,RW, 4'b1111, 32'h0000_4000, 32'h1,        0, 32'h0,         1, 0, 1'b0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0});
      vq.push_back('{"lhu",   OP_LD, RHU, 4'b0000, 32'h0000_5002, 32'h0,        0, 32'h8001_0000, 2, 1, 1'b0, 32'h0000_5000, 4'b1100, 32'h0,        1'b1, 32'h0000_8001, 1'b0, 1'b0});
      vq.push_back('{"sb",    OP_ST, RB,  4'b0001, 32'h0000_6001, 32'h0000_00A5, 1, 32'h0,         3, 2, 1'b1, 32'h0000_6000, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0,        1'b0, 1'b0});
      vq.push_back('{"sh_mis",OP_ST, RH,  4'b0011, 32'h0000_6003, 32'h0000_1234, 0, 32'h0,         1, 0, 1'b0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0});
      vq.push_back('{"ld_rtnone",OP_LD,RN,4'b0000, 32'h0000_7003, 32'h0,        0, 32'h0,         1, 0, 1'b0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0});
      vq.push_back('{"lb_pos",OP_LD, RB,  4'b0000, 32'h0000_8001, 32'h0,        0, 32'h0000_7F00, 2, 1, 1'b0, 32'h0000_8000, 4'b0010, 32'h0,        1'b1, 32'h0000_007F, 1'b0, 1'b0});
      vq.push_back('{"lw",    OP_LD, RW,  4'b0000, 32'h0000_9000, 32'h0,        2, 32'hCAFE_F00D, 4, 3, 1'b0, 32'h0000_9000, 4'b1111, 32'h0,        1'b1, 32'hCAFE_F00D, 1'b0, 1'b0});

      foreach (vq[i]) run_vec(vq[i]);

      // start pulses during BUS and DONE are ignored; start right after done is accepted
      @(negedge clk);
      start = 1'b1; mem_op = OP_LD; mem_read_type = RW; mem_write_mask = 4'b0; addr = 32'h0000_0100;
      @(negedge clk);                                   // cycle 1: BUS
      chk("ign.busy_in_bus", 32'(busy), 32'd1);
      chk("ign.req_c1", 32'(bus_req), 32'd1);
      start = 1'b1; mem_op = OP_NONE;
      @(negedge clk);                                   // cycle 2: still BUS
      start = 1'b0;
      chk("ign.done_c2", 32'(done), 32'd0);
      chk("ign.req_c2", 32'(bus_req), 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
      @(negedge clk);                                   // cycle 3: DONE
      bus_ack = 1'b0;
      chk("ign.done_c3", 32'(done), 32'd1);
      chk("ign.rdata_c3", rdata, 32'h0BAD_F00D);
      start = 1'b1;
      @(negedge clk);                                   // cycle 4: IDLE, start accepted here
      chk("ign.done_c4", 32'(done), 32'd0);
      @(negedge clk);                                   // cycle 5
      start = 1'b0;
      chk("ign.done_c5", 32'(done), 32'd1);
      chk("ign.rdata_c5", rdata, 32'd0);
      @(negedge clk);
      chk("ign.done_c6", 32'(done), 32'd0);

      // reset in the second BUS cycle
      idle_inputs();
      @(negedge clk);
      start = 1'b1; mem_op = OP_ST; mem_read_type = RW; mem_write_mask = 4'b1111;
      addr = 32'h0000_A000; wdata = 32'h5555_AAAA;
      @(negedge clk);
      start = 1'b0;
      chk("rstmid.req_c1", 32'(bus_req), 32'd1);
      @(negedge clk);
      chk("rstmid.req_c2", 32'(bus_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid.req_now", 32'(bus_req), 32'd0);
      chk("rstmid.busy", 32'(busy), 32'd0);
      chk("rstmid.bus_be", 32'(bus_be), 32'd0);
      chk("rstmid.bus_addr", bus_addr, 32'd0);
      chk("rstmid.bus_wdata", bus_wdata, 32'd0);
      chk("rstmid.bus_we", 32'(bus_we), 32'd0);
      @(negedge clk);
      rst = 1'b0; bus_ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus_ack = 1'b0;
         chk($sformatf("rstmid.no_done%0d", c), 32'(done), 32'd0);
         chk($sformatf("rstmid.no_req%0d", c), 32'(bus_req), 32'd0);
      end

      // unit still works normally after the mid-access reset
      run_vec(vq[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential memory-access engine that executes the load/store commands produced by the instruction decoder. It takes the decoded memory operation, read type and write mask plus the effective address and store data, then drives a word-addressed, byte-enabled request/acknowledge data bus. It returns the loaded value aligned and sign- or zero-extended for register writeback, and flags misaligned accesses and bus timeouts. It sits between the execute stage and the data memory/peripheral interconnect.

## Interface
- TIMEOUT_CYCLES, 255: cycles in BUS state without bus_ack before the access aborts; legal range 1..65535.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- mem_op  in  2  `MEM_OP_NONE` / `MEM_OP_LOAD` / `MEM_OP_STORE` (defines.v).
- mem_read_type  in  3  `MEM_RD_BYTE/HALF/WORD/B_U/H_U/NONE`.
- mem_write_mask  in  4  unshifted byte mask: sb 0001, sh 0011, sw 1111, none 0000.
- addr  in  32  effective byte address.
- wdata  in  32  store data (rs2), low bits significant.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid while done=1, held until next accept.
- misaligned  out  1  valid with done; access not issued to bus.
- timeout  out  1  valid with done; bus never acknowledged.
- bus_req  out  1  request; held until bus_ack or timeout.
- bus_we  out  1  1 = write.
- bus_addr  out  32  {addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  responder acknowledge; completes a request in the same cycle.
- bus_rdata  in  32  read word; sampled when bus_req && bus_ack.

## Operation
- States: IDLE, BUS, DONE.
- IDLE, start=1: latch mem_op, read type, mask, addr[1:0], wdata; clear flags.
  - mem_op NONE -> DONE (no bus cycle, rdata=0).
  - Misaligned (half: addr[0]=1; word: addr[1:0]≠0; applies to loads and stores) -> DONE with misaligned=1, rdata=0.
  - Load/store with mem_read_type NONE or mask 0000 -> treated as NONE.
  - Otherwise -> BUS; timeout counter cleared.
- BUS: bus_req=1, bus_addr/bus_we/bus_be/bus_wdata stable.
  - bus_ack=1 -> capture and extend bus_rdata (loads), -> DONE.
  - Counter increments each cycle without ack; at TIMEOUT_CYCLES -> DONE with timeout=1, rdata=0. Ack in the same cycle as expiry wins.
- DONE: done=1 one cycle -> IDLE.
- Store lanes: bus_be = mask << addr[1:0]; bus_wdata = byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extract: word shifted right by 8*addr[1:0]; BYTE sign-extends bit 7, B_U zero-extends; HALF sign-extends bit 15, H_U zero-extends; WORD unchanged. Loads drive bus_be from the read-type width mask, shifted the same way.
- start while busy or in DONE: ignored. bus_ack outside BUS: ignored.

## Timing
- Reset: state IDLE; busy, done, misaligned, timeout, bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata, rdata = 0; counter = 0.
- Reset mid-access: bus_req drops immediately (asynchronous); no done is produced; a later ack is ignored.
- start accepted in cycle 0 -> bus_req high in cycle 1; ack in cycle k (k≥1) -> done in cycle k+1. Minimum bus access: done 2 cycles after start.
- Non-bus completion (NONE/misaligned): done in cycle 1.
- Timeout: bus_req high for exactly TIMEOUT_CYCLES cycles, done the next cycle.
- Back-to-back: next start accepted in the cycle after done.
- All bus outputs registered; no combinational path from bus_ack to bus outputs.

## Test plan
- lb, addr 0x1003, bus_rdata 0x80FF_1234, ack in cycle 1 -> bus_addr 0x1000, bus_be 1000, done cycle 2, rdata 0xFFFF_FF80; same with lbu -> 0x0000_0080.
- sh, addr 0x2002, wdata 0xDEAD_BEEF, ack after 3 wait cycles -> bus_we=1, bus_be 1100, bus_wdata 0xBEEF_BEEF, bus_req high 4 cycles, done cycle 5.
- lw, addr 0x3001 -> no bus_req, done cycle 1 with misaligned=1, rdata 0; lh addr 0x3002 aligned, bus_rdata 0x8001_0000 -> rdata 0xFFFF_8001.
- TIMEOUT_CYCLES=4, sw with bus_ack held 0 -> bus_req high 4 cycles, done with timeout=1; ack on 4th cycle instead -> timeout=0.
- start pulsed during BUS and during DONE -> ignored, one done only; start in the cycle after done accepted.
- rst asserted in the 2nd BUS cycle -> bus_req 0 immediately, all outputs reset, no done; late bus_ack ignored.
